// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO result register pair with MDU pending/drain tracking
//
// Purpose: holds the HI and LO registers written by direct moves, full
// 2*WIDTH writes, multiply-accumulate/subtract and multi-cycle MDU results.
// It tracks a pending MDU op and stalls reads and writes until the result lands.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   wr_en/wr_op         direct write request and operation (0 HI, 1 LO, 2 both,
//                       3 acc add, 4 acc sub, 5-7 no-op)
//   wr_hi/wr_lo/wr_prod write data and the 2*WIDTH accumulate operand
//   mdu_start/mdu_done  MDU issue and result-valid strobes
//   mdu_hi/mdu_lo       MDU result
//   flush               pipeline squash
//   rd_req              read-stage consumer of HI/LO
//   hi_rdata/lo_rdata   read data (bypassed when BYPASS=1)
//   rd_stall/wr_stall   hold requests for the read and write sides
//   busy                an MDU op is pending or being drained
module hilo_unit #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [2:0]         wr_op,
  input  logic [WIDTH-1:0]   wr_hi,
  input  logic [WIDTH-1:0]   wr_lo,
  input  logic [2*WIDTH-1:0] wr_prod,
  input  logic               mdu_start,
  input  logic               mdu_done,
  input  logic [WIDTH-1:0]   mdu_hi,
  input  logic [WIDTH-1:0]   mdu_lo,
  input  logic               flush,
  input  logic               rd_req,
  output logic [WIDTH-1:0]   hi_rdata,
  output logic [WIDTH-1:0]   lo_rdata,
  output logic               rd_stall,
  output logic               wr_stall,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic               wr_commit;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] acc_diff;

  // Modular 2*WIDTH arithmetic: the carry/borrow out of the top bit is dropped.
  assign acc_sum  = {hi_q, lo_q} + wr_prod;
  assign acc_diff = {hi_q, lo_q} - wr_prod;

  // A direct write only lands when nothing is pending and the same cycle
  // neither starts an MDU op nor squashes the pipeline.
  assign wr_commit = wr_en && (state_q == ST_IDLE) && !mdu_start && !flush;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (mdu_start && !flush) state_d = ST_PEND;
      end
      ST_PEND: begin
        // A result arriving alongside a flush still belongs to an older,
        // committed instruction, so it is written back.
        if (mdu_done) begin
          state_d = ST_IDLE;
          hi_d    = mdu_hi;
          lo_d    = mdu_lo;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The squashed op's result is waited out and thrown away.
        if (mdu_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_commit) begin
      case (wr_op)
        3'd0: hi_d = wr_hi;
        3'd1: lo_d = wr_lo;
        3'd2: begin
          hi_d = wr_hi;
          lo_d = wr_lo;
        end
        3'd3: {hi_d, lo_d} = acc_sum;
        3'd4: {hi_d, lo_d} = acc_diff;
        default: ;
      endcase
    end

    // Reset is folded into the next-state value so that it overrides every
    // input and the bypassed read ports also show zero while it is asserted.
    if (reset) begin
      state_d = ST_IDLE;
      hi_d    = '0;
      lo_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    hi_q    <= hi_d;
    lo_q    <= lo_d;
  end

  assign busy     = (state_q != ST_IDLE);
  assign wr_stall = wr_en && (state_q != ST_IDLE);
  // With bypass, the arriving MDU result is forwarded, so the reader need not wait.
  assign rd_stall = rd_req && (state_q != ST_IDLE) &&
                    !(BYPASS && (state_q == ST_PEND) && mdu_done);

  assign hi_rdata = BYPASS ? hi_d : hi_q;
  assign lo_rdata = BYPASS ? lo_d : lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed self-checking bench for hilo_unit
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_op;
  logic [31:0] wr_hi, wr_lo;
  logic [63:0] wr_prod;
  logic        mdu_start, mdu_done;
  logic [31:0] mdu_hi, mdu_lo;
  logic        flush, rd_req;

  logic [31:0] b_hi, b_lo, r_hi, r_lo;
  logic        b_rs, b_ws, b_busy, r_rs, r_ws, r_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hilo_unit #(.WIDTH(32), .BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_op(wr_op), .wr_hi(wr_hi),
    .wr_lo(wr_lo), .wr_prod(wr_prod), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .mdu_hi(mdu_hi), .mdu_lo(mdu_lo), .flush(flush), .rd_req(rd_req),
    .hi_rdata(b_hi), .lo_rdata(b_lo), .rd_stall(b_rs), .wr_stall(b_ws), .busy(b_busy)
  );

  hilo_unit #(.WIDTH(32), .BYPASS(1'b0)) u_reg (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_op(wr_op), .wr_hi(wr_hi),
    .wr_lo(wr_lo), .wr_prod(wr_prod), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .mdu_hi(mdu_hi), .mdu_lo(mdu_lo), .flush(flush), .rd_req(rd_req),
    .hi_rdata(r_hi), .lo_rdata(r_lo), .rd_stall(r_rs), .wr_stall(r_ws), .busy(r_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] op, input logic [31:0] h, input logic [31:0] l,
                          input logic [63:0] p);
    wr_en = 1'b1; wr_op = op; wr_hi = h; wr_lo = l; wr_prod = p;
    step();
    wr_en = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_op = 3'd0; wr_hi = '0; wr_lo = '0; wr_prod = '0;
    mdu_start = 1'b0; mdu_done = 1'b0; mdu_hi = '0; mdu_lo = '0; flush = 1'b0; rd_req = 1'b0;
    step(); step();
    reset = 1'b0; rd_req = 1'b1;
    #1;
    tests++; if (r_hi !== 32'h0 || r_lo !== 32'h0) begin fails++; $display("FAIL reset_regs got %h_%h want 0_0", r_hi, r_lo); end
    tests++; if (b_hi !== 32'h0 || b_lo !== 32'h0) begin fails++; $display("FAIL reset_rdata_byp got %h_%h want 0_0", b_hi, b_lo); end
    tests++; if (b_busy !== 1'b0 || b_rs !== 1'b0 || b_ws !== 1'b0) begin fails++; $display("FAIL reset_flags got busy=%b rs=%b ws=%b want 0 0 0", b_busy, b_rs, b_ws); end
    rd_req = 1'b0;
  endtask

  task automatic test_write_both();
    wr_en = 1'b1; wr_op = 3'd2; wr_hi = 32'h1234_5678; wr_lo = 32'h9ABC_DEF0;
    #1;
    tests++; if (b_hi !== 32'h1234_5678 || b_lo !== 32'h9ABC_DEF0) begin fails++; $display("FAIL write_bypass got %h_%h want 12345678_9abcdef0", b_hi, b_lo); end
    tests++; if (r_hi !== 32'h0 || r_lo !== 32'h0) begin fails++; $display("FAIL write_nobypass_same_cycle got %h_%h want 0_0", r_hi, r_lo); end
    step();
    wr_en = 1'b0;
    #1;
    tests++; if (r_hi !== 32'h1234_5678 || r_lo !== 32'h9ABC_DEF0) begin fails++; $display("FAIL write_registered got %h_%h want 12345678_9abcdef0", r_hi, r_lo); end
    tests++; if (b_hi !== 32'h1234_5678 || b_lo !== 32'h9ABC_DEF0) begin fails++; $display("FAIL write_registered_byp got %h_%h want 12345678_9abcdef0", b_hi, b_lo); end
  endtask

  task automatic test_partial();
    do_write(3'd0, 32'h1111_1111, 32'h2222_2222, 64'h0);
    tests++; if (r_hi !== 32'h1111_1111 || r_lo !== 32'h9ABC_DEF0) begin fails++; $display("FAIL op_hi got %h_%h want 11111111_9abcdef0", r_hi, r_lo); end
    do_write(3'd1, 32'h4444_4444, 32'h3333_3333, 64'h0);
    tests++; if (r_hi !== 32'h1111_1111 || r_lo !== 32'h3333_3333) begin fails++; $display("FAIL op_lo got %h_%h want 11111111_33333333", r_hi, r_lo); end
    do_write(3'd6, 32'h5555_5555, 32'h6666_6666, 64'h7);
    tests++; if (r_hi !== 32'h1111_1111 || r_lo !== 32'h3333_3333) begin fails++; $display("FAIL op_noop got %h_%h want 11111111_33333333", r_hi, r_lo); end
  endtask

  task automatic test_accum();
    do_write(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0);
    do_write(3'd3, 32'h0, 32'h0, 64'h1);
    tests++; if (r_hi !== 32'h0 || r_lo !== 32'h0) begin fails++; $display("FAIL acc_add_wrap got %h_%h want 0_0", r_hi, r_lo); end
    do_write(3'd4, 32'h0, 32'h0, 64'h1);
    tests++; if (r_hi !== 32'hFFFF_FFFF || r_lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL acc_sub_wrap got %h_%h want ffffffff_ffffffff", r_hi, r_lo); end
    do_write(3'd2, 32'h0, 32'hFFFF_FFFF, 64'h0);
    do_write(3'd3, 32'h0, 32'h0, 64'h1);
    tests++; if (r_hi !== 32'h1 || r_lo !== 32'h0) begin fails++; $display("FAIL acc_add_carry got %h_%h want 1_0", r_hi, r_lo); end
    do_write(3'd4, 32'h0, 32'h0, 64'h2_0000_0000);
    tests++; if (r_hi !== 32'hFFFF_FFFF || r_lo !== 32'h0) begin fails++; $display("FAIL acc_sub_borrow got %h_%h want ffffffff_0", r_hi, r_lo); end
  endtask

  task automatic test_mdu_read();
    mdu_start = 1'b1;
    #1;
    tests++; if (b_busy !== 1'b0) begin fails++; $display("FAIL busy_start_cycle got %b want 0", b_busy); end
    step();
    mdu_start = 1'b0; rd_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      #1;
      tests++; if (b_rs !== 1'b1 || r_rs !== 1'b1 || b_busy !== 1'b1) begin fails++; $display("FAIL pend_rd_stall_c%0d got rs=%b/%b busy=%b want 1/1 1", i, b_rs, r_rs, b_busy); end
      step();
    end
    mdu_done = 1'b1; mdu_hi = 32'hA; mdu_lo = 32'hB;
    #1;
    tests++; if (b_rs !== 1'b0 || r_rs !== 1'b1) begin fails++; $display("FAIL done_rd_stall got byp=%b reg=%b want 0 1", b_rs, r_rs); end
    tests++; if (b_hi !== 32'hA || b_lo !== 32'hB) begin fails++; $display("FAIL done_bypass_rdata got %h_%h want a_b", b_hi, b_lo); end
    step();
    mdu_done = 1'b0; rd_req = 1'b0;
    #1;
    tests++; if (b_busy !== 1'b0 || r_busy !== 1'b0) begin fails++; $display("FAIL busy_after_done got %b/%b want 0/0", b_busy, r_busy); end
    tests++; if (r_hi !== 32'hA || r_lo !== 32'hB) begin fails++; $display("FAIL mdu_writeback got %h_%h want a_b", r_hi, r_lo); end
  endtask

  task automatic test_flush_drain();
    mdu_start = 1'b1;
    step();
    mdu_start = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step(); step();
    mdu_done = 1'b1; mdu_hi = 32'hDEAD; mdu_lo = 32'hBEEF;
    #1;
    tests++; if (b_busy !== 1'b1) begin fails++; $display("FAIL drain_busy_done got %b want 1", b_busy); end
    tests++; if (b_hi !== 32'hA || b_lo !== 32'hB) begin fails++; $display("FAIL drain_no_bypass got %h_%h want a_b", b_hi, b_lo); end
    step();
    mdu_done = 1'b0;
    #1;
    tests++; if (r_hi !== 32'hA || r_lo !== 32'hB || r_busy !== 1'b0) begin fails++; $display("FAIL drain_discard got %h_%h busy=%b want a_b 0", r_hi, r_lo, r_busy); end
  endtask

  task automatic test_stalled_write();
    mdu_start = 1'b1;
    step();
    mdu_start = 1'b0;
    wr_en = 1'b1; wr_op = 3'd1; wr_lo = 32'h55; wr_hi = 32'h66;
    #1;
    tests++; if (b_ws !== 1'b1 || r_ws !== 1'b1) begin fails++; $display("FAIL pend_wr_stall got %b/%b want 1/1", b_ws, r_ws); end
    step();
    tests++; if (r_lo !== 32'hB) begin fails++; $display("FAIL pend_lo_unchanged got %h want b", r_lo); end
    mdu_done = 1'b1; mdu_hi = 32'h1; mdu_lo = 32'h2;
    #1;
    tests++; if (b_ws !== 1'b1) begin fails++; $display("FAIL done_cycle_wr_stall got %b want 1", b_ws); end
    step();
    mdu_done = 1'b0;
    #1;
    tests++; if (b_ws !== 1'b0 || r_hi !== 32'h1 || r_lo !== 32'h2) begin fails++; $display("FAIL idle_before_commit got ws=%b %h_%h want 0 1_2", b_ws, r_hi, r_lo); end
    tests++; if (b_lo !== 32'h55 || b_hi !== 32'h1) begin fails++; $display("FAIL held_write_bypass got %h_%h want 1_55", b_hi, b_lo); end
    step();
    wr_en = 1'b0;
    #1;
    tests++; if (r_hi !== 32'h1 || r_lo !== 32'h55) begin fails++; $display("FAIL held_write_commit got %h_%h want 1_55", r_hi, r_lo); end
  endtask

  task automatic test_flush_drops();
    mdu_start = 1'b1; flush = 1'b1;
    step();
    mdu_start = 1'b0;
    #1;
    tests++; if (b_busy !== 1'b0) begin fails++; $display("FAIL start_flush_dropped got busy=%b want 0", b_busy); end
    do_write(3'd2, 32'h77, 32'h88, 64'h0);
    flush = 1'b0;
    #1;
    tests++; if (r_hi !== 32'h1 || r_lo !== 32'h55) begin fails++; $display("FAIL write_flush_dropped got %h_%h want 1_55", r_hi, r_lo); end
    mdu_done = 1'b1; mdu_hi = 32'h99; mdu_lo = 32'h99;
    step();
    mdu_done = 1'b0;
    #1;
    tests++; if (r_hi !== 32'h1 || r_lo !== 32'h55 || r_busy !== 1'b0) begin fails++; $display("FAIL idle_done_ignored got %h_%h busy=%b want 1_55 0", r_hi, r_lo, r_busy); end
  endtask

  task automatic test_reset_midop();
    mdu_start = 1'b1;
    step();
    mdu_start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    tests++; if (r_busy !== 1'b0 || r_hi !== 32'h0 || r_lo !== 32'h0) begin fails++; $display("FAIL reset_in_pend got busy=%b %h_%h want 0 0_0", r_busy, r_hi, r_lo); end
    step();
    mdu_done = 1'b1; mdu_hi = 32'h7; mdu_lo = 32'h8;
    step();
    mdu_done = 1'b0;
    #1;
    tests++; if (r_busy !== 1'b0 || r_hi !== 32'h0 || r_lo !== 32'h0) begin fails++; $display("FAIL done_after_reset got busy=%b %h_%h want 0 0_0", r_busy, r_hi, r_lo); end
  endtask

  initial begin
    test_reset();
    test_write_both();
    test_partial();
    test_accum();
    test_mdu_read();
    test_flush_drain();
    test_stalled_write();
    test_flush_drops();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
